// File: rtl/miner_nonce_scheduler.sv
// Nonce-range sequencer for an array of mining cores. It gives each core a slice of
// the nonce space, runs them for a cycle budget per epoch and captures the first solution.
module miner_nonce_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 64,
    parameter int CNT_W     = 32,
    parameter int EPOCH_W   = 16,
    localparam int WIN_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic                           cfg_halt,
    input  logic                           cfg_auto,
    input  logic [NONCE_W-1:0]             cfg_base_nonce,
    input  logic [5:0]                     cfg_slice_log2,
    input  logic [CNT_W-1:0]               cfg_budget,
    input  logic [NUM_CORES-1:0]           core_found,
    input  logic [NUM_CORES*NONCE_W-1:0]   core_solution,
    output logic [NUM_CORES-1:0]           core_run,
    output logic [NUM_CORES*NONCE_W-1:0]   core_start_nonce,
    output logic                           busy,
    output logic                           done,
    output logic                           found,
    output logic [NONCE_W-1:0]             solution,
    output logic [WIN_W-1:0]               winner,
    output logic [EPOCH_W-1:0]             epoch,
    output logic                           irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = {{(EPOCH_W-1){1'b0}}, 1'b1};

    state_e                         state_q, state_d;
    logic [NONCE_W-1:0]             base_q, base_d;
    logic [5:0]                     slice_q, slice_d;
    logic [CNT_W-1:0]               budget_q, budget_d;
    logic                           auto_q, auto_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [EPOCH_W-1:0]             epoch_q, epoch_d;
    logic                           found_q, found_d;
    logic                           done_q, done_d;
    logic                           irq_q, irq_d;
    logic                           busy_q, busy_d;
    logic [NUM_CORES-1:0]           run_q, run_d;
    logic [NUM_CORES*NONCE_W-1:0]   start_q, start_d;
    logic [NONCE_W-1:0]             solution_q, solution_d;
    logic [WIN_W-1:0]               winner_q, winner_d;
    logic [NONCE_W-1:0]             stride_s;

    // A shift of NONCE_W or more naturally yields zero, which is the intended wrap behaviour.
    function automatic logic [NONCE_W-1:0] slice_offset(input logic [NONCE_W-1:0] idx,
                                                        input logic [5:0]         sh);
        return idx << sh;
    endfunction

    function automatic logic [WIN_W-1:0] lowest_set(input logic [NUM_CORES-1:0] vec);
        logic [WIN_W-1:0] idx;
        idx = {WIN_W{1'b0}};
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = WIN_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [NONCE_W-1:0] pick_solution(input logic [NUM_CORES-1:0]         vec,
                                                         input logic [NUM_CORES*NONCE_W-1:0] sols);
        logic [NONCE_W-1:0] sol;
        sol = {NONCE_W{1'b0}};
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                sol = sols[i*NONCE_W +: NONCE_W];
            end
        end
        return sol;
    endfunction

    assign stride_s = slice_offset(NONCE_W'(NUM_CORES), slice_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a find outranks halt, and halt outranks budget expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cfg_halt) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((|core_found) || cfg_halt) begin
                    state_d = ST_STOP;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = auto_q ? ST_LOAD : ST_STOP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values for the current state.
    always_comb begin
        base_d     = base_q;
        slice_d    = slice_q;
        budget_d   = budget_q;
        auto_d     = auto_q;
        cnt_d      = cnt_q;
        epoch_d    = epoch_q;
        found_d    = found_q;
        done_d     = done_q;
        solution_d = solution_q;
        winner_d   = winner_q;
        start_d    = start_q;
        irq_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    base_d   = cfg_base_nonce;
                    slice_d  = cfg_slice_log2;
                    budget_d = cfg_budget;
                    auto_d   = cfg_auto;
                    epoch_d  = {EPOCH_W{1'b0}};
                    found_d  = 1'b0;
                    done_d   = 1'b0;
                end else begin
                    done_d   = done_q;
                end
            end
            ST_LOAD: begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    start_d[i*NONCE_W +: NONCE_W] = base_q + slice_offset(NONCE_W'(i), slice_q);
                end
                cnt_d = (budget_q == {CNT_W{1'b0}}) ? CNT_ONE : budget_q;
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (|core_found) begin
                    found_d    = 1'b1;
                    winner_d   = lowest_set(core_found);
                    solution_d = pick_solution(core_found, core_solution);
                end else if (cfg_halt) begin
                    found_d    = 1'b0;
                end else if ((cnt_q == CNT_ONE) && auto_q) begin
                    base_d     = base_q + stride_s;
                    epoch_d    = epoch_q + EPOCH_ONE;
                end else begin
                    found_d    = found_q;
                end
            end
            ST_STOP: begin
                done_d = 1'b1;
                irq_d  = found_q;
            end
            default: begin
                irq_d = 1'b0;
            end
        endcase
        run_d  = (state_d == ST_RUN) ? {NUM_CORES{1'b1}} : {NUM_CORES{1'b0}};
        busy_d = (state_d != ST_IDLE);
    end

    // Datapath and output registers; reset clears every output, dropping core_run at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= {NONCE_W{1'b0}};
            slice_q    <= 6'd0;
            budget_q   <= {CNT_W{1'b0}};
            auto_q     <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            epoch_q    <= {EPOCH_W{1'b0}};
            found_q    <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
            run_q      <= {NUM_CORES{1'b0}};
            start_q    <= {(NUM_CORES*NONCE_W){1'b0}};
            solution_q <= {NONCE_W{1'b0}};
            winner_q   <= {WIN_W{1'b0}};
        end else begin
            base_q     <= base_d;
            slice_q    <= slice_d;
            budget_q   <= budget_d;
            auto_q     <= auto_d;
            cnt_q      <= cnt_d;
            epoch_q    <= epoch_d;
            found_q    <= found_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
            run_q      <= run_d;
            start_q    <= start_d;
            solution_q <= solution_d;
            winner_q   <= winner_d;
        end
    end

    assign core_run         = run_q;
    assign core_start_nonce = start_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign found            = found_q;
    assign solution         = solution_q;
    assign winner           = winner_q;
    assign epoch            = epoch_q;
    assign irq              = irq_q;

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// Directed scoreboard bench for miner_nonce_scheduler with four cores.
module tb_miner_nonce_scheduler;

    localparam int NC = 4;
    localparam int NW = 64;
    localparam int CW = 32;
    localparam int EW = 16;
    localparam int WW = 2;

    logic              clk;
    logic              rst;
    logic              cfg_start;
    logic              cfg_halt;
    logic              cfg_auto;
    logic [NW-1:0]     cfg_base_nonce;
    logic [5:0]        cfg_slice_log2;
    logic [CW-1:0]     cfg_budget;
    logic [NC-1:0]     core_found;
    logic [NC*NW-1:0]  core_solution;
    logic [NC-1:0]     core_run;
    logic [NC*NW-1:0]  core_start_nonce;
    logic              busy;
    logic              done;
    logic              found;
    logic [NW-1:0]     solution;
    logic [WW-1:0]     winner;
    logic [EW-1:0]     epoch;
    logic              irq;

    int          checks  = 0;
    int          errors  = 0;
    int          irq_cnt = 0;
    int          run_len;
    logic [63:0] exp_q[$];

    miner_nonce_scheduler #(
        .NUM_CORES(NC), .NONCE_W(NW), .CNT_W(CW), .EPOCH_W(EW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_halt(cfg_halt), .cfg_auto(cfg_auto),
        .cfg_base_nonce(cfg_base_nonce), .cfg_slice_log2(cfg_slice_log2), .cfg_budget(cfg_budget),
        .core_found(core_found), .core_solution(core_solution), .core_run(core_run),
        .core_start_nonce(core_start_nonce), .busy(busy), .done(done), .found(found),
        .solution(solution), .winner(winner), .epoch(epoch), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (irq === 1'b1) irq_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic chk_nonces(input string tag);
        for (int i = 0; i < NC; i++) begin
            chk_pop(tag, core_start_nonce[i*NW +: NW]);
        end
    endtask

    // Called at the first RUN negedge; returns at the first negedge with core_run low.
    task automatic measure_run(output int n);
        n = 0;
        while (core_run !== 4'b0000 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Pulse start, then scramble the config inputs to prove they were latched.
    task automatic start_job(input logic [63:0] base, input logic [5:0] sl,
                             input logic [31:0] bud, input logic au);
        cfg_base_nonce = base;
        cfg_slice_log2 = sl;
        cfg_budget     = bud;
        cfg_auto       = au;
        cfg_start      = 1'b1;
        @(negedge clk);
        cfg_start      = 1'b0;
        cfg_base_nonce = ~base;
        cfg_slice_log2 = sl + 6'd1;
        cfg_budget     = 32'd77;
        cfg_auto       = ~au;
    endtask

    initial begin
        rst = 1'b0; cfg_start = 1'b0; cfg_halt = 1'b0; cfg_auto = 1'b0;
        cfg_base_nonce = 64'd0; cfg_slice_log2 = 6'd0; cfg_budget = 32'd0;
        core_found = 4'b0000; core_solution = {(NC*NW){1'b0}};
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_core_run", 64'(core_run), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_found", 64'(found), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rst_epoch", 64'(epoch), 64'h0);
        chk("rst_solution", solution, 64'h0);
        chk("rst_winner", 64'(winner), 64'h0);
        chk("rst_start_nonce", 64'(|core_start_nonce), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Plain job: budget 10, no finds.
        exp_q.push_back(64'h100); exp_q.push_back(64'h200);
        exp_q.push_back(64'h300); exp_q.push_back(64'h400);
        exp_q.push_back(64'd10);  exp_q.push_back(64'd0);
        start_job(64'h100, 6'd8, 32'd10, 1'b0);
        chk("a_load_busy", 64'(busy), 64'h1);
        chk("a_load_run", 64'(core_run), 64'h0);
        @(negedge clk);
        chk("a_run_all", 64'(core_run), 64'hF);
        chk_nonces("a_nonce");
        measure_run(run_len);
        chk_pop("a_run_len", 64'(run_len));
        chk_pop("a_found", 64'(found));
        chk("a_stop_busy", 64'(busy), 64'h1);
        @(negedge clk);
        chk("a_done", 64'(done), 64'h1);
        chk("a_idle_busy", 64'(busy), 64'h0);
        @(negedge clk);
        chk("a_no_irq", 64'(irq_cnt), 64'd0);

        // Cores 1 and 3 find together with a halt in the same cycle.
        exp_q.push_back(64'h100); exp_q.push_back(64'h200);
        exp_q.push_back(64'h300); exp_q.push_back(64'h400);
        exp_q.push_back(64'd1);   exp_q.push_back(64'h2AB);
        start_job(64'h100, 6'd8, 32'd10, 1'b0);
        @(negedge clk);
        chk_nonces("b_nonce");
        @(negedge clk);
        core_solution = {64'h4CD, 64'h777, 64'h2AB, 64'h999};
        core_found    = 4'b1010;
        cfg_halt      = 1'b1;
        @(negedge clk);
        core_found = 4'b0000;
        cfg_halt   = 1'b0;
        chk("b_run_low", 64'(core_run), 64'h0);
        chk("b_found", 64'(found), 64'h1);
        chk_pop("b_winner", 64'(winner));
        chk_pop("b_solution", solution);
        chk("b_irq_early", 64'(irq), 64'h0);
        chk("b_done_early", 64'(done), 64'h0);
        @(negedge clk);
        chk("b_irq", 64'(irq), 64'h1);
        chk("b_done", 64'(done), 64'h1);
        @(negedge clk);
        chk("b_irq_pulse", 64'(irq), 64'h0);
        chk("b_irq_cnt", 64'(irq_cnt), 64'd1);

        // Auto-advance with base wrap, then halt exactly at budget expiry.
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FF00); exp_q.push_back(64'hFFFF_FFFF_FFFF_FF40);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FF80); exp_q.push_back(64'hFFFF_FFFF_FFFF_FFC0);
        exp_q.push_back(64'd5);   exp_q.push_back(64'd1);
        exp_q.push_back(64'h0);   exp_q.push_back(64'h40);
        exp_q.push_back(64'h80);  exp_q.push_back(64'hC0);
        start_job(64'hFFFF_FFFF_FFFF_FF00, 6'd6, 32'd5, 1'b1);
        chk("c_epoch0", 64'(epoch), 64'd0);
        chk("c_found_clr", 64'(found), 64'h0);
        @(negedge clk);
        chk_nonces("c_nonce_e0");
        measure_run(run_len);
        chk_pop("c_run_len", 64'(run_len));
        chk("c_load_busy", 64'(busy), 64'h1);
        chk_pop("c_epoch1", 64'(epoch));
        @(negedge clk);
        chk("c_run_e1", 64'(core_run), 64'hF);
        chk_nonces("c_nonce_e1");
        repeat (4) @(negedge clk);
        cfg_halt = 1'b1;
        @(negedge clk);
        cfg_halt = 1'b0;
        chk("c_halt_run", 64'(core_run), 64'h0);
        chk("c_halt_busy", 64'(busy), 64'h1);
        chk("c_halt_epoch", 64'(epoch), 64'd1);
        @(negedge clk);
        chk("c_idle_busy", 64'(busy), 64'h0);
        chk("c_done", 64'(done), 64'h1);
        chk("c_found", 64'(found), 64'h0);

        // Halt at RUN cycle 3; a start while busy is ignored.
        start_job(64'h100, 6'd8, 32'd10, 1'b0);
        @(negedge clk);
        @(negedge clk);
        cfg_base_nonce = 64'h5000;
        cfg_start      = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_halt  = 1'b1;
        @(negedge clk);
        cfg_halt = 1'b0;
        chk("d_stop_run", 64'(core_run), 64'h0);
        chk("d_stop_done", 64'(done), 64'h0);
        @(negedge clk);
        chk("d_done", 64'(done), 64'h1);
        chk("d_found", 64'(found), 64'h0);
        @(negedge clk);
        chk("d_start_ignored", 64'(busy), 64'h0);
        chk("d_nonce_hold", core_start_nonce[NW-1:0], 64'h100);

        // Halt in LOAD while core_found is held: the find must be ignored.
        core_solution = {64'h0, 64'h0, 64'h0, 64'h123};
        core_found    = 4'b0001;
        start_job(64'h40, 6'd0, 32'd3, 1'b0);
        cfg_halt = 1'b1;
        @(negedge clk);
        cfg_halt   = 1'b0;
        core_found = 4'b0000;
        chk("e_halt_load_run", 64'(core_run), 64'h0);
        chk("e_halt_load_busy", 64'(busy), 64'h1);
        chk("e_found_ignored", 64'(found), 64'h0);
        chk("e_nonce3", core_start_nonce[3*NW +: NW], 64'h43);
        @(negedge clk);
        chk("e_done", 64'(done), 64'h1);
        chk("e_irq_cnt", 64'(irq_cnt), 64'd1);

        // Budget 0 runs one cycle; slice 63 overflows the odd-index terms.
        exp_q.push_back(64'h5); exp_q.push_back(64'h8000_0000_0000_0005);
        exp_q.push_back(64'h5); exp_q.push_back(64'h8000_0000_0000_0005);
        exp_q.push_back(64'd1);
        start_job(64'h5, 6'd63, 32'd0, 1'b0);
        @(negedge clk);
        chk_nonces("f_nonce");
        measure_run(run_len);
        chk_pop("f_run_len", 64'(run_len));
        @(negedge clk);
        chk("f_done", 64'(done), 64'h1);

        // Asynchronous reset in the middle of epoch 2.
        start_job(64'h1000, 6'd4, 32'd2, 1'b1);
        repeat (7) @(negedge clk);
        chk("g_pre_run", 64'(core_run), 64'hF);
        chk("g_pre_epoch", 64'(epoch), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("g_async_run", 64'(core_run), 64'h0);
        chk("g_async_busy", 64'(busy), 64'h0);
        chk("g_async_epoch", 64'(epoch), 64'd0);
        chk("g_async_nonce", 64'(|core_start_nonce), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("g_idle_after", 64'(busy), 64'h0);
        chk("g_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miner_nonce_scheduler.md
# miner_nonce_scheduler

Sequencer that shares one nonce search across `NUM_CORES` instances of the SHA3-256 mining core. It partitions a 64-bit nonce range into per-core slices, loads each core's start nonce, and runs all cores for a cycle budget. On the first solution it stops every core and captures the winning nonce; otherwise it advances to the next epoch or stops. It sits between the Avalon register file and the core array, in the miner clock domain.

## Interface
- `NUM_CORES`, 4: number of mining cores driven (1..16).
- `NONCE_W`, 64: nonce width.
- `CNT_W`, 32: budget counter width.
- `EPOCH_W`, 16: epoch counter width.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_start` in 1: one-cycle start pulse; sampled only in IDLE.
- `cfg_halt` in 1: one-cycle abort pulse; honoured in LOAD and RUN.
- `cfg_auto` in 1: auto-advance enable; latched on start.
- `cfg_base_nonce` in NONCE_W: first nonce of epoch 0; latched on start.
- `cfg_slice_log2` in 6: log2 of the per-core slice size; latched on start.
- `cfg_budget` in CNT_W: RUN cycles per epoch; 0 is treated as 1.
- `core_found` in NUM_CORES: per-core solution-found level.
- `core_solution` in NUM_CORES*NONCE_W: per-core solution nonce; core i occupies bits [i*NONCE_W +: NONCE_W].
- `core_run` out NUM_CORES: per-core run enable.
- `core_start_nonce` out NUM_CORES*NONCE_W: per-core start nonce; same packing as `core_solution`.
- `busy` out 1: high in LOAD, RUN, and STOP.
- `done` out 1: high in IDLE after a completed job; cleared by the next accepted start.
- `found` out 1: the last job ended with a solution.
- `solution` out NONCE_W: captured winning nonce.
- `winner` out max(1,$clog2(NUM_CORES)): index of the winning core.
- `epoch` out EPOCH_W: number of epochs started minus 1 in the current job.
- `irq` out 1: one-cycle pulse when a job ends with `found`=1.

## Operation
- States: IDLE, LOAD, RUN, STOP.
- **IDLE**
  - On `cfg_start`: latch base, slice, budget, and auto.
  - Clear `epoch`, `found`, and `done`; go to LOAD.
  - A `cfg_start` pulse outside IDLE is ignored.
- **LOAD** (1 cycle)
  - `core_start_nonce[i]` <= base + (i << slice), modulo 2^NONCE_W.
  - Counter <= max(budget,1); `core_run`=0.
  - Go to RUN unless `cfg_halt` is asserted, in which case go to STOP.
- **RUN**
  - `core_run` = all ones; the counter decrements each cycle.
  - Exit checks, highest priority first:
    - Any `core_found` bit: winner = lowest set index; capture its `core_solution` into `solution`; `found`<=1; go to STOP.
    - `cfg_halt`: go to STOP with `found`=0.
    - Counter == 1 and `cfg_auto`=1: base += NUM_CORES << slice (wraps); `epoch`++ (wraps); go to LOAD.
    - Counter == 1 and `cfg_auto`=0: go to STOP with `found`=0.
- **STOP** (1 cycle)
  - `core_run`=0.
  - Next state is IDLE with `done`<=1; `irq`<=`found` for exactly that one cycle.
- `core_found` is ignored outside RUN.
- Slice shifts ≥ NONCE_W yield 0 for that term; no error is raised.
- `core_start_nonce` holds its value until the next LOAD.
- Reset
  - Asserting `rst` at any time forces IDLE immediately.
  - All outputs go to 0, including `core_run`, `core_start_nonce`, `solution`, `winner`, and `epoch`.
  - Reset mid-RUN drops `core_run` asynchronously.

## Timing
- All outputs are registered.
- `cfg_start` sampled at edge t: LOAD in cycle t+1; `core_start_nonce` valid and `core_run`=1 from t+2.
- With budget B and no find, RUN lasts exactly B cycles; with auto, LOAD follows, so each epoch costs B+1 cycles.
- `core_found` sampled at edge r:
  - `found`, `solution`, `winner` valid and `core_run`=0 at r+1 (STOP).
  - `done`=1 and `irq` pulse at r+2.
- Simultaneous events:
  - Found and halt in the same cycle: found wins.
  - Found and budget expiry in the same cycle: found wins.
  - Halt and expiry: halt wins, with no epoch advance.

## Test plan
- NUM_CORES=4, base=0x100, slice=8, budget=10, auto=0, no finds: start nonces 0x100, 0x200, 0x300, 0x400; `core_run` high exactly 10 cycles; `done`=1, `found`=0, no `irq`.
- Same config, cores 1 and 3 found in the same RUN cycle, with solutions 0x2AB and 0x4CD: `winner`=1, `solution`=0x2AB, `core_run` low the next cycle, `irq` a 1-cycle pulse 2 cycles after detection.
- auto=1, budget=5, base=0xFFFF_FFFF_FFFF_FF00, slice=6: after the first epoch base wraps to 0x0; core0 start nonce is 0x0 and `epoch`=1.
- `cfg_halt` during RUN at count 3 of budget 10: STOP next cycle, `found`=0, `done`=1; a `cfg_start` pulse issued while `busy` is ignored.
- budget=0: RUN lasts 1 cycle. `rst` asserted mid-RUN: `core_run`, `busy`, and `epoch` go to 0 without waiting for a clock edge.
